// File: rtl/debug_unit_pkg.sv
// Shared constants and state encoding for the UART debug unit.
// Command codes, program terminator and FSM states.
package debug_unit_pkg;

  localparam int ADDRWIDTH = 10;

  localparam logic [7:0] CMD_LOAD = 8'h4C;
  localparam logic [7:0] CMD_CONT = 8'h43;
  localparam logic [7:0] CMD_STEP = 8'h53;

  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LOAD_RX,
    ST_LOAD_WR,
    ST_RUN,
    ST_STEP,
    ST_DUMP_SETUP,
    ST_DUMP_READ,
    ST_DUMP_TX,
    ST_DUMP_TXWAIT
  } state_t;

endpackage

// File: rtl/debug_unit_if.sv
// UART and pipeline-side signal bundle of the debug unit.
// master = debug unit side, slave = UART/pipeline side.
interface debug_unit_if #(
  parameter int NB_DATA = 32,
  parameter int NB_BYTE = 8,
  parameter int NB_REG  = 5,
  parameter int AW      = debug_unit_pkg::ADDRWIDTH
);
  logic [NB_BYTE-1:0] i_rx_data;
  logic               i_rx_done;
  logic               i_tx_done;
  logic [NB_BYTE-1:0] o_tx_data;
  logic               o_tx_start;
  logic [AW-1:0]      i_pc;
  logic [NB_DATA-1:0] i_data_reg;
  logic [NB_DATA-1:0] i_data_mem;
  logic               i_halt;
  logic [NB_DATA-1:0] o_im_data;
  logic [AW-1:0]      o_im_addr;
  logic               o_im_enable_write;
  logic               o_en_read;
  logic               o_enable_pipe;
  logic               o_debug_unit;
  logic [NB_REG-1:0]  o_br_addr;
  logic               o_br_enable;
  logic [AW-1:0]      o_dm_addr;
  logic               o_dm_enable;
  logic               o_dm_enable_addr;

  modport master (
    input  i_rx_data, i_rx_done, i_tx_done,
    input  i_pc, i_data_reg, i_data_mem, i_halt,
    output o_tx_data, o_tx_start,
    output o_im_data, o_im_addr, o_im_enable_write,
    output o_en_read, o_enable_pipe, o_debug_unit,
    output o_br_addr, o_br_enable,
    output o_dm_addr, o_dm_enable, o_dm_enable_addr
  );

  modport slave (
    output i_rx_data, i_rx_done, i_tx_done,
    output i_pc, i_data_reg, i_data_mem, i_halt,
    input  o_tx_data, o_tx_start,
    input  o_im_data, o_im_addr, o_im_enable_write,
    input  o_en_read, o_enable_pipe, o_debug_unit,
    input  o_br_addr, o_br_enable,
    input  o_dm_addr, o_dm_enable, o_dm_enable_addr
  );

endinterface

// File: rtl/debug_unit_word_serializer.sv
// Holds one dump word and presents it byte by byte, MSB first.
// o_done pulses on the handshake that retires the last byte.
module word_serializer #(
  parameter int NB_DATA = 32,
  parameter int NB_BYTE = 8
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_load,
  input  logic [NB_DATA-1:0] i_word,
  input  logic               i_next,
  output logic [NB_BYTE-1:0] o_byte,
  output logic               o_done
);
  localparam int N_BYTES = NB_DATA / NB_BYTE;
  localparam int NB_CNT  = $clog2(N_BYTES);

  logic [NB_DATA-1:0] r_shift;
  logic [NB_CNT-1:0]  r_cnt;
  logic               w_last;

  assign w_last = (r_cnt == NB_CNT'(N_BYTES - 1));
  assign o_byte = r_shift[NB_DATA-1 -: NB_BYTE];
  assign o_done = i_next && w_last;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_shift <= '0;
      r_cnt   <= '0;
    end else if (i_load) begin
      r_shift <= i_word;
      r_cnt   <= '0;
    end else if (i_next) begin
      r_shift <= r_shift << NB_BYTE;
      r_cnt   <= w_last ? '0 : r_cnt + NB_CNT'(1);
    end
  end

endmodule

// File: rtl/debug_unit.sv
// UART debug controller: loads IM, runs/steps the pipeline,
// then streams PC, register file and data memory back out.
module debug_unit #(
  parameter int NB_DATA    = 32,
  parameter int NB_BYTE    = 8,
  parameter int NB_REG     = 5,
  parameter int N_REGISTER = 32,
  parameter int N_DM_WORDS = 32,
  parameter logic [NB_DATA-1:0] HALT_WORD = debug_unit_pkg::HALT_WORD
) (
  input logic          i_clock,
  input logic          i_reset,
  debug_unit_if.master bus
);
  import debug_unit_pkg::*;

  localparam int N_WORDS  = N_REGISTER + N_DM_WORDS + 1;
  localparam int NB_WIDX  = $clog2(N_WORDS);
  localparam int NB_IMIDX = ADDRWIDTH - 2;

  state_t r_state;
  state_t w_next;

  logic [1:0]          r_bcnt;
  logic [NB_DATA-1:0]  r_word;
  logic [NB_IMIDX-1:0] r_im_idx;
  logic [NB_WIDX-1:0]  r_widx;
  logic                r_halted;

  logic w_is_load, w_is_cont, w_is_step, w_accept_load;
  logic w_is_reg, w_is_dm, w_last_word;
  logic w_ser_next, w_ser_done;
  logic [NB_BYTE-1:0]   w_ser_byte;
  logic [NB_DATA-1:0]   w_dump_word;
  logic [NB_REG-1:0]    w_reg_idx;
  logic [ADDRWIDTH-1:0] w_dm_addr;

  assign w_is_load = (bus.i_rx_data == CMD_LOAD);
  assign w_is_cont = (bus.i_rx_data == CMD_CONT);
  assign w_is_step = (bus.i_rx_data == CMD_STEP);
  assign w_accept_load = (r_state == ST_IDLE) && bus.i_rx_done && w_is_load;

  // dump word 0 is the PC, then registers, then DM words
  assign w_is_reg = (r_widx != '0) && (r_widx <= NB_WIDX'(N_REGISTER));
  assign w_is_dm  = (r_widx > NB_WIDX'(N_REGISTER));
  assign w_last_word = (r_widx == NB_WIDX'(N_WORDS - 1));
  assign w_reg_idx = NB_REG'(r_widx - NB_WIDX'(1));
  assign w_dm_addr =
    ADDRWIDTH'({r_widx - NB_WIDX'(N_REGISTER + 1), 2'b00});

  always_comb begin
    w_dump_word = NB_DATA'(bus.i_pc);
    if (w_is_dm)
      w_dump_word = bus.i_data_mem;
    else if (w_is_reg)
      w_dump_word = bus.i_data_reg;
  end

  assign w_ser_next = (r_state == ST_DUMP_TXWAIT) && bus.i_tx_done;

  word_serializer #(
    .NB_DATA (NB_DATA),
    .NB_BYTE (NB_BYTE)
  ) u_ser (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_load  (r_state == ST_DUMP_READ),
    .i_word  (w_dump_word),
    .i_next  (w_ser_next),
    .o_byte  (w_ser_byte),
    .o_done  (w_ser_done)
  );

  always_ff @(posedge i_clock) begin
    if (i_reset) r_state <= ST_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (bus.i_rx_done) begin
          unique case (1'b1)
            w_is_load: w_next = ST_LOAD_RX;
            w_is_cont: w_next = r_halted ? ST_IDLE : ST_RUN;
            w_is_step: w_next = r_halted ? ST_IDLE : ST_STEP;
            default:   w_next = ST_IDLE;
          endcase
        end
      end
      ST_LOAD_RX:
        if (bus.i_rx_done && r_bcnt == 2'd3) w_next = ST_LOAD_WR;
      ST_LOAD_WR:
        w_next = (r_word == HALT_WORD) ? ST_IDLE : ST_LOAD_RX;
      ST_RUN:
        if (bus.i_halt) w_next = ST_DUMP_SETUP;
      ST_STEP:       w_next = ST_DUMP_SETUP;
      ST_DUMP_SETUP: w_next = ST_DUMP_READ;
      ST_DUMP_READ:  w_next = ST_DUMP_TX;
      ST_DUMP_TX:    w_next = ST_DUMP_TXWAIT;
      ST_DUMP_TXWAIT: begin
        if (bus.i_tx_done) begin
          if (!w_ser_done)     w_next = ST_DUMP_TX;
          else if (w_last_word) w_next = ST_IDLE;
          else                 w_next = ST_DUMP_SETUP;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_bcnt   <= '0;
      r_word   <= '0;
      r_im_idx <= '0;
      r_widx   <= '0;
      r_halted <= 1'b0;
    end else begin
      if (w_accept_load) begin
        r_halted <= 1'b0;
        r_im_idx <= '0;
        r_bcnt   <= '0;
      end else if (bus.i_halt) begin
        r_halted <= 1'b1;
      end
      if (r_state == ST_LOAD_RX && bus.i_rx_done) begin
        r_word <= {r_word[NB_DATA-NB_BYTE-1:0], bus.i_rx_data};
        r_bcnt <= (r_bcnt == 2'd3) ? 2'd0 : r_bcnt + 2'd1;
      end
      if (r_state == ST_LOAD_WR && r_im_idx != '1)
        r_im_idx <= r_im_idx + NB_IMIDX'(1);
      if (r_state == ST_STEP || (r_state == ST_RUN && bus.i_halt))
        r_widx <= '0;
      else if (w_ser_next && w_ser_done && !w_last_word)
        r_widx <= r_widx + NB_WIDX'(1);
    end
  end

  always_comb begin
    bus.o_tx_data         = '0;
    bus.o_tx_start        = 1'b0;
    bus.o_im_data         = '0;
    bus.o_im_addr         = '0;
    bus.o_im_enable_write = 1'b0;
    bus.o_en_read         = 1'b0;
    bus.o_enable_pipe     = 1'b0;
    bus.o_debug_unit      = 1'b0;
    bus.o_br_addr         = '0;
    bus.o_br_enable       = 1'b0;
    bus.o_dm_addr         = '0;
    bus.o_dm_enable       = 1'b0;
    bus.o_dm_enable_addr  = 1'b0;
    unique case (r_state)
      ST_LOAD_RX: bus.o_debug_unit = 1'b1;
      ST_LOAD_WR: begin
        bus.o_debug_unit      = 1'b1;
        bus.o_im_enable_write = 1'b1;
        bus.o_im_data         = r_word;
        bus.o_im_addr         = {r_im_idx, 2'b00};
      end
      ST_RUN: begin
        bus.o_enable_pipe = 1'b1;
        bus.o_en_read     = 1'b1;
      end
      ST_STEP: bus.o_enable_pipe = 1'b1;
      ST_DUMP_SETUP, ST_DUMP_READ: begin
        bus.o_debug_unit = 1'b1;
        if (w_is_reg) begin
          bus.o_br_addr   = w_reg_idx;
          bus.o_br_enable = (r_state == ST_DUMP_SETUP);
        end
        if (w_is_dm) begin
          bus.o_dm_addr        = w_dm_addr;
          bus.o_dm_enable      = (r_state == ST_DUMP_SETUP);
          bus.o_dm_enable_addr = (r_state == ST_DUMP_SETUP);
        end
      end
      ST_DUMP_TX: begin
        bus.o_debug_unit = 1'b1;
        bus.o_tx_start   = 1'b1;
        bus.o_tx_data    = w_ser_byte;
      end
      ST_DUMP_TXWAIT: begin
        bus.o_debug_unit = 1'b1;
        bus.o_tx_data    = w_ser_byte;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_debug_unit.sv
// Randomized bench for debug_unit with pipeline/UART models
// and a dump/load reference built from the command rules.
module tb_debug_unit;
  import debug_unit_pkg::*;

  localparam int NO = 53 + 2 * ADDRWIDTH;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  debug_unit_if bus ();
  debug_unit u_dut (.i_clock(clk), .i_reset(rst), .bus(bus));

  int checks = 0;
  int errors = 0;

  logic [31:0] regs [32];
  logic [31:0] dm [32];
  logic [7:0]  rx_q[$];
  logic [7:0]  exp_q[$];
  logic [ADDRWIDTH-1:0] wa_q[$];
  logic [31:0] wd_q[$];

  int cyc = 0, pipe_cnt = 0, last_pipe = 0, first_start = -1;
  int extra_start = 0, tx_delay = 1, cnt = 0;
  bit pend = 0, tx_rand = 0;

  logic [NO-1:0] outs;
  assign outs = {bus.o_tx_data, bus.o_tx_start, bus.o_im_data,
                 bus.o_im_addr, bus.o_im_enable_write, bus.o_en_read,
                 bus.o_enable_pipe, bus.o_debug_unit, bus.o_br_addr,
                 bus.o_br_enable, bus.o_dm_addr, bus.o_dm_enable,
                 bus.o_dm_enable_addr};

  // register file / data memory with one-cycle read latency
  always @(posedge clk) begin
    if (bus.o_br_enable) bus.i_data_reg <= regs[bus.o_br_addr];
    if (bus.o_dm_enable) bus.i_data_mem <= dm[bus.o_dm_addr[6:2]];
  end

  // UART transmitter model plus activity monitor
  initial begin
    bus.i_tx_done = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      bus.i_tx_done = 1'b0;
      if (rst) pend = 0;
      if (pend) begin
        cnt = cnt - 1;
        if (cnt == 0) begin
          bus.i_tx_done = 1'b1;
          pend = 0;
        end
      end
      if (bus.o_im_enable_write === 1'b1) begin
        wa_q.push_back(bus.o_im_addr);
        wd_q.push_back(bus.o_im_data);
      end
      if (bus.o_enable_pipe === 1'b1) begin
        pipe_cnt++;
        last_pipe = cyc;
      end
      if (bus.o_tx_start === 1'b1) begin
        if (pend) extra_start++;
        if (first_start < 0) first_start = cyc;
        rx_q.push_back(bus.o_tx_data);
        pend = 1;
        cnt = tx_rand ? int'($urandom_range(5, 1)) : tx_delay;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    bus.i_rx_data = b;
    bus.i_rx_done = 1'b1;
    @(negedge clk);
    bus.i_rx_done = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int b = 3; b >= 0; b--) send_byte(w[8*b +: 8]);
  endtask

  task automatic wait_rx(input int n, input int budget);
    for (int i = 0; i < budget && rx_q.size() < n; i++)
      @(negedge clk);
  endtask

  task automatic fill(input bit rnd);
    for (int i = 0; i < 32; i++) begin
      regs[i] = rnd ? $urandom : 32'(i);
      dm[i]   = rnd ? $urandom : 32'hA5A5A5A5;
    end
    bus.i_pc = rnd ? ADDRWIDTH'($urandom) : ADDRWIDTH'(8);
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int b = 3; b >= 0; b--) exp_q.push_back(w[8*b +: 8]);
  endtask

  // expected stream: PC, every register, every DM word
  task automatic build_exp();
    exp_q.delete();
    push_word(32'(bus.i_pc));
    for (int i = 0; i < 32; i++) push_word(regs[i]);
    for (int i = 0; i < 32; i++) push_word(dm[i]);
  endtask

  function automatic int first_diff();
    for (int i = 0; i < exp_q.size(); i++)
      if (i >= rx_q.size() || rx_q[i] !== exp_q[i]) return i;
    if (rx_q.size() != exp_q.size()) return exp_q.size();
    return -1;
  endfunction

  function automatic logic [7:0] got_at(input int i);
    return (i >= 0 && i < rx_q.size()) ? rx_q[i] : 8'h00;
  endfunction

  function automatic logic [7:0] exp_at(input int i);
    return (i >= 0 && i < exp_q.size()) ? exp_q[i] : 8'h00;
  endfunction

  task automatic clear_mon();
    rx_q.delete();
    wa_q.delete();
    wd_q.delete();
    first_start = -1;
    extra_start = 0;
  endtask

  task automatic test_reset();
    bus.i_rx_data = '0;
    bus.i_rx_done = 1'b0;
    bus.i_halt    = 1'b0;
    bus.i_pc      = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (outs !== '0) begin
      errors++;
      $display("FAIL reset_hold: outs=%h expected 0", outs);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (outs !== '0) begin
      errors++;
      $display("FAIL reset_release: outs=%h expected 0", outs);
    end
  endtask

  task automatic test_invalid();
    logic [7:0] b;
    clear_mon();
    pipe_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      b = (i == 0) ? 8'h00 : 8'($urandom);
      if (b == CMD_LOAD || b == CMD_CONT || b == CMD_STEP) b = 8'h00;
      send_byte(b);
      checks++;
      if (outs !== '0 || pipe_cnt != 0 || wa_q.size() != 0) begin
        errors++;
        $display("FAIL invalid_byte %h: outs=%h pipe=%0d wr=%0d expected 0",
                 b, outs, pipe_cnt, wa_q.size());
      end
    end
  endtask

  task automatic test_load_fixed();
    logic [7:0] prog [8];
    prog = '{8'h12, 8'h34, 8'h56, 8'h78, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    clear_mon();
    send_byte(CMD_LOAD);
    send_byte(prog[0]);
    checks++;
    if (bus.o_debug_unit !== 1'b1) begin
      errors++;
      $display("FAIL load_owner: debug_unit=%b expected 1", bus.o_debug_unit);
    end
    for (int i = 1; i < 8; i++) send_byte(prog[i]);
    repeat (2) @(negedge clk);
    checks++;
    if (wa_q.size() != 2) begin
      errors++;
      $display("FAIL load_count: writes=%0d expected 2", wa_q.size());
    end else begin
      checks++;
      if (wa_q[0] !== 0 || wd_q[0] !== 32'h12345678) begin
        errors++;
        $display("FAIL load_w0: addr=%0d data=%h expected 0 12345678",
                 wa_q[0], wd_q[0]);
      end
      checks++;
      if (wa_q[1] !== 4 || wd_q[1] !== 32'hFFFFFFFF) begin
        errors++;
        $display("FAIL load_w1: addr=%0d data=%h expected 4 ffffffff",
                 wa_q[1], wd_q[1]);
      end
    end
    checks++;
    if (outs !== '0) begin
      errors++;
      $display("FAIL load_exit: outs=%h expected 0", outs);
    end
  endtask

  task automatic test_load_random();
    logic [31:0] words[$];
    int n, bad;
    for (int rep = 0; rep < 2; rep++) begin
      clear_mon();
      words.delete();
      n = $urandom_range(6, 1);
      for (int i = 0; i < n; i++) begin
        words.push_back($urandom);
        if (words[i] == 32'hFFFFFFFF) words[i] = 32'h0;
      end
      words.push_back(32'hFFFFFFFF);
      send_byte(CMD_LOAD);
      foreach (words[i]) send_word(words[i]);
      repeat (2) @(negedge clk);
      bad = (wa_q.size() != words.size()) ? 1 : 0;
      for (int i = 0; i < words.size() && i < wa_q.size(); i++)
        if (wa_q[i] !== ADDRWIDTH'(4 * i) || wd_q[i] !== words[i]) bad++;
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL load_rand%0d: %0d bad of %0d writes, expected %0d",
                 rep, bad, wa_q.size(), words.size());
      end
    end
  endtask

  task automatic test_step();
    int d;
    fill(0);
    build_exp();
    clear_mon();
    pipe_cnt = 0;
    tx_rand = 0;
    tx_delay = 3;
    send_byte(CMD_STEP);
    wait_rx(10, 500);
    send_byte(CMD_LOAD);
    wait_rx(260, 5000);
    repeat (20) @(negedge clk);
    checks++;
    if (pipe_cnt != 1) begin
      errors++;
      $display("FAIL step_enable: cycles=%0d expected 1", pipe_cnt);
    end
    checks++;
    if (first_start - last_pipe != 3) begin
      errors++;
      $display("FAIL step_latency: %0d expected 3", first_start - last_pipe);
    end
    d = first_diff();
    checks++;
    if (d != -1) begin
      errors++;
      $display("FAIL step_dump: byte %0d got %h expected %h (n=%0d)",
               d, got_at(d), exp_at(d), rx_q.size());
    end
    checks++;
    if (extra_start != 0 || wa_q.size() != 0 || outs !== '0) begin
      errors++;
      $display("FAIL step_clean: extra=%0d wr=%0d outs=%h expected 0 0 0",
               extra_start, wa_q.size(), outs);
    end
  endtask

  task automatic test_random_dumps();
    int d;
    tx_rand = 1;
    for (int k = 0; k < 3; k++) begin
      fill(1);
      build_exp();
      clear_mon();
      send_byte(CMD_STEP);
      wait_rx(260, 5000);
      repeat (10) @(negedge clk);
      d = first_diff();
      checks++;
      if (d != -1 || extra_start != 0) begin
        errors++;
        $display("FAIL rand_dump%0d: byte %0d got %h expected %h extra=%0d",
                 k, d, got_at(d), exp_at(d), extra_start);
      end
    end
    tx_rand = 0;
  endtask

  task automatic test_backpressure();
    int d;
    fill(1);
    build_exp();
    clear_mon();
    tx_delay = 100;
    send_byte(CMD_STEP);
    wait_rx(260, 30000);
    repeat (120) @(negedge clk);
    d = first_diff();
    checks++;
    if (d != -1) begin
      errors++;
      $display("FAIL bp_dump: byte %0d got %h expected %h (n=%0d)",
               d, got_at(d), exp_at(d), rx_q.size());
    end
    checks++;
    if (extra_start != 0) begin
      errors++;
      $display("FAIL bp_handshake: early starts=%0d expected 0", extra_start);
    end
    tx_delay = 2;
  endtask

  task automatic test_reset_mid();
    int n, d;
    fill(1);
    build_exp();
    clear_mon();
    tx_delay = 2;
    send_byte(CMD_STEP);
    wait_rx(70, 2000);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (outs !== '0) begin
      errors++;
      $display("FAIL rst_mid_outs: outs=%h expected 0", outs);
    end
    rst = 1'b0;
    n = rx_q.size();
    repeat (30) @(negedge clk);
    checks++;
    if (rx_q.size() != n) begin
      errors++;
      $display("FAIL rst_mid_quiet: bytes=%0d expected %0d", rx_q.size(), n);
    end
    clear_mon();
    send_byte(CMD_STEP);
    wait_rx(260, 5000);
    repeat (10) @(negedge clk);
    d = first_diff();
    checks++;
    if (d != -1) begin
      errors++;
      $display("FAIL rst_mid_redump: byte %0d got %h expected %h",
               d, got_at(d), exp_at(d));
    end
  endtask

  task automatic test_run();
    int n, d, p;
    fill(1);
    build_exp();
    clear_mon();
    pipe_cnt = 0;
    tx_rand = 1;
    bus.i_rx_data = CMD_CONT;
    bus.i_rx_done = 1'b1;
    @(negedge clk);
    bus.i_rx_done = 1'b0;
    n = 0;
    for (int i = 0; i < 200 && n < 50; i++) begin
      if (bus.o_enable_pipe === 1'b1) n++;
      if (n < 50) @(negedge clk);
    end
    // halt and a stray load byte in the same RUN cycle
    bus.i_halt = 1'b1;
    bus.i_rx_data = CMD_LOAD;
    bus.i_rx_done = 1'b1;
    @(negedge clk);
    bus.i_halt = 1'b0;
    bus.i_rx_done = 1'b0;
    wait_rx(260, 5000);
    repeat (10) @(negedge clk);
    checks++;
    if (pipe_cnt != 50) begin
      errors++;
      $display("FAIL run_enable: cycles=%0d expected 50", pipe_cnt);
    end
    checks++;
    if (first_start - last_pipe != 3) begin
      errors++;
      $display("FAIL run_latency: %0d expected 3", first_start - last_pipe);
    end
    d = first_diff();
    checks++;
    if (d != -1 || wa_q.size() != 0) begin
      errors++;
      $display("FAIL run_dump: byte %0d got %h expected %h wr=%0d",
               d, got_at(d), exp_at(d), wa_q.size());
    end
    clear_mon();
    p = pipe_cnt;
    send_byte(CMD_STEP);
    send_byte(CMD_CONT);
    repeat (30) @(negedge clk);
    checks++;
    if (pipe_cnt != p || rx_q.size() != 0 || outs !== '0) begin
      errors++;
      $display("FAIL halted_ignore: pipe=%0d bytes=%0d outs=%h expected %0d 0 0",
               pipe_cnt, rx_q.size(), outs, p);
    end
    send_byte(CMD_LOAD);
    send_word(32'hFFFFFFFF);
    send_byte(CMD_STEP);
    wait_rx(260, 5000);
    repeat (10) @(negedge clk);
    checks++;
    if (pipe_cnt != p + 1 || rx_q.size() != 260) begin
      errors++;
      $display("FAIL halt_clear: pipe=%0d bytes=%0d expected %0d 260",
               pipe_cnt, rx_q.size(), p + 1);
    end
    tx_rand = 0;
  endtask

  initial begin
    test_reset();
    test_invalid();
    test_load_fixed();
    test_load_random();
    test_step();
    test_random_dumps();
    test_backpressure();
    test_reset_mid();
    test_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/debug_unit.md
# debug_unit

UART-side controller that sits directly upstream of `pipeline`. Accepts byte commands from the UART receiver and loads instruction memory word by word. Runs the pipeline either continuously or one clock at a time. After each run or step it streams PC, register file and data-memory contents back through the UART transmitter. It is the sole driver of the pipeline's debug/enable inputs.

## Interface
Parameters:
- `NB_DATA`, 32, pipeline data width.
- `NB_BYTE`, 8, UART byte width.
- `NB_REG`, 5, register-address width.
- `N_REGISTER`, 32, registers dumped.
- `N_DM_WORDS`, 32, data-memory words dumped.
- `HALT_WORD`, 32'hFFFF_FFFF, program terminator word.
- Address width is `` `ADDRWIDTH `` from `parameters.vh`.

Ports:
- `i_clock` in 1: single clock.
- `i_reset` in 1: synchronous, active-high.
- `i_rx_data` in 8: received byte.
- `i_rx_done` in 1: one-cycle pulse, `i_rx_data` valid.
- `i_tx_done` in 1: one-cycle pulse, transmitter finished the previous byte.
- `o_tx_data` out 8: byte to send.
- `o_tx_start` out 1: one-cycle send request.
- `i_pc` in ADDRWIDTH: pipeline PC (`o_data_send_pc`).
- `i_data_reg` in 32: register read data.
- `i_data_mem` in 32: data-memory read data.
- `i_halt` in 1: halt reached WB.
- `o_im_data` out 32, `o_im_addr` out ADDRWIDTH, `o_im_enable_write` out 1: IM write port.
- `o_en_read` out 1: IM read enable.
- `o_enable_pipe` out 1: pipeline advance enable.
- `o_debug_unit` out 1: debug owns memories.
- `o_br_addr` out 5, `o_br_enable` out 1: register debug read.
- `o_dm_addr` out ADDRWIDTH, `o_dm_enable` out 1, `o_dm_enable_addr` out 1: data-memory debug read.

## Operation
- Command bytes, accepted only in IDLE:
  - 0x4C `L`: load program.
  - 0x43 `C`: run continuous.
  - 0x53 `S`: single step.
  - Any other byte is dropped.
- **LOAD**
  - `o_debug_unit=1`.
  - Four received bytes, MSB first, assemble a word.
  - On the 4th byte, `o_im_enable_write` pulses 1 cycle with `o_im_data`=word and `o_im_addr`=word index×4. The index then increments.
  - A word equal to `HALT_WORD` is written and then LOAD exits to IDLE.
  - The word index resets to 0 on every `L`.
  - A `L` clears the `halted` flag.
- **RUN**: `o_enable_pipe=1` and `o_en_read=1` every cycle until `i_halt` is sampled high, then enter DUMP.
- **STEP**: `o_enable_pipe=1` for exactly one cycle, then enter DUMP.
- `C` and `S` are ignored while the `halted` flag is set. The flag is set by `i_halt` and cleared by reset or `L`.
- **DUMP** sequence:
  - PC: 4 bytes.
  - Registers 0..N_REGISTER-1: 4 bytes each.
  - DM words 0..N_DM_WORDS-1: 4 bytes each, `o_dm_addr`=index×4.
  - All words are sent MSB first: 4+128+128=260 bytes by default. Then return to IDLE.
  - Per word: drive the address with enable high (SETUP), wait one cycle (READ), latch the 32-bit word, then send 4 bytes.
  - Per byte: pulse `o_tx_start` and wait for `i_tx_done`.
- Word-index and byte counters do not wrap. The terminal count selects the next state.
- FSM states: IDLE, LOAD_RX, LOAD_WR, RUN, STEP, DUMP_SETUP, DUMP_READ, DUMP_TX, DUMP_TXWAIT.

## Timing
- Reset values: all outputs 0 and state IDLE. The word and byte counters and the `halted` flag are all 0.
- Register and memory debug reads have 1-cycle latency. Data is sampled in DUMP_READ, the cycle after SETUP.
- IM write occurs the cycle after the 4th `i_rx_done`.
- First `o_tx_start` of a dump:
  - For `S`: 3 cycles after the STEP cycle.
  - For `C`: 3 cycles after the `i_halt` sample.
- `o_tx_start` is high only in DUMP_TX, exactly one cycle per byte. The next byte is never requested before `i_tx_done`.
- `i_rx_done` during RUN, STEP or DUMP is ignored. No buffering.
- `i_halt` and `i_rx_done` arriving in the same RUN cycle: the halt wins.
- Reset at any point, including mid-dump or mid-word, aborts the operation. Partial words are discarded and no further `o_tx_start` is issued.

## Structure
- Add to a shared package or header (`parameters.vh`): command codes `CMD_LOAD`, `CMD_CONT`, `CMD_STEP`, `HALT_WORD`, and the state encodings.
- One natural sub-module, `word_serializer`: it latches a 32-bit word and emits 4 bytes MSB first under the `o_tx_start`/`i_tx_done` handshake. It asserts a done pulse when finished.
- The FSM and counters stay in `debug_unit`.

## Test plan
- **Load**: `L`, 12 34 56 78, FF FF FF FF → two IM writes:
  - addr 0, data 0x12345678.
  - addr 4, data 0xFFFFFFFF.
  - Then return to IDLE with `o_debug_unit` back to 0.
- **Step**: `S` with `i_pc`=0x8, all registers = index, all DM = 0xA5A5A5A5:
  - Exactly one `o_enable_pipe` cycle.
  - 260 bytes starting 00 00 00 08, 00 00 00 00, 00 00 00 01…
  - Last 4 bytes are A5.
- **Run**: `C`, then `i_halt` raised after 50 cycles → `o_enable_pipe` is high exactly 50 cycles, then a 260-byte dump. A subsequent `S` produces no activity.
- **Backpressure**: `i_tx_done` delayed 100 cycles per byte → exactly one `o_tx_start` per `i_tx_done`, with byte order unchanged.
- **Reset mid-dump**: `i_reset` pulsed after byte 70 → all outputs 0 next cycle and no further `o_tx_start`. A new `S` restarts the dump at the PC.
- **Invalid byte**: 0x00 in IDLE → no output change.
